mic1_mem_bridge: RTL
====================

# mic1_mem_bridge

Memory-side bridge between the mic1 datapath and a single-port, word-addressed main-memory bus with a req/ack handshake.
- Accepts the microinstruction's rd/wr/fetch strobes and serialises them onto the bus.
- Holds a one-word instruction fetch buffer so sequential opcode fetches mostly avoid the bus.
- Freezes the datapath with `cpu_stall` until the results of the previous cycle's strobes are in place.
- Sits directly downstream of mic1, between its MAR/MDR/PC ports and the memory.

## Interface
- `TIMEOUT`, 255: bus wait cycles before a transfer is aborted (1..65535).
- `clk` in 1: system clock, all state on rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `cpu_addr` in 32: word address (MAR).
- `cpu_wdata` in 32: write data (MDR).
- `cpu_pc` in 32: byte address of the opcode fetch (PC).
- `cpu_read`, `cpu_write`, `cpu_fetch` in 1 each: microinstruction memory strobes.
- `cpu_rdata` out 32: read result, loaded into MDR by the CPU.
- `cpu_ibyte` out 8: fetched byte, loaded into MBR by the CPU.
- `cpu_stall` out 1: registered; the CPU treats it as a clock-enable low.
- `bus_req` out 1: transfer request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_ack` in 1: transfer complete, sampled on `clk` while `bus_req`=1.
- `err` out 1: sticky; set on timeout or on `cpu_read` and `cpu_write` in the same cycle.

## Operation
- **FSM states:** IDLE, DATA, FETCH.
- **IDLE, sampling:** strobes are sampled only in IDLE, at a rising edge with `cpu_stall`=0. `cpu_addr`, `cpu_wdata` and `cpu_pc` are latched with them.
- **Read+write together:** write performed, read dropped, `err` set.
- **Data op pending:** go to DATA.
- **Fetch only, buffer hit** (valid and `cpu_pc[31:2]`==tag): `cpu_ibyte` updated at that edge, no bus access, stay IDLE.
- **Fetch only, miss:** go to FETCH.
- **DATA:**
  - Drive `bus_req`=1, `bus_we`, `bus_addr`=latched `cpu_addr`, and `bus_wdata`.
  - On ack, a read captures `bus_rdata` into `cpu_rdata`.
  - A write whose word matches the buffer tag clears buffer valid.
  - Next state: FETCH if a fetch is pending and misses (hit check done after the invalidation), else IDLE.
  - A pending fetch that hits completes in the same edge.
- **FETCH:**
  - Drive `bus_req`=1, `bus_we`=0, `bus_addr`={2'b00, `cpu_pc[31:2]`}.
  - On ack, load the buffer word, tag and valid=1, and output the selected byte; go to IDLE.
- **Byte select** (big-endian): PC[1:0]=0 gives bits 31:24, 1 gives 23:16, 2 gives 15:8, 3 gives 7:0.
- **Outputs when idle:** `cpu_rdata` and `cpu_ibyte` hold their last value until overwritten.
- **Timeout:** a wait counter is cleared on entry to DATA/FETCH.
  - If it reaches `TIMEOUT` without ack, the transfer aborts: `err`=1.
  - Read data and fetch byte return all-ones (0xFFFFFFFF / 0xFF); the buffer is not loaded.
  - The FSM proceeds as if acked.
- **Reset mid-transfer:** `bus_req` drops asynchronously and pending ops are discarded.
- **Reset values:** all outputs 0, buffer valid 0, state IDLE, `err` 0.

## Timing
- **Stall:** `cpu_stall`=1 exactly in the cycles the FSM is in DATA or FETCH; it falls in the cycle after the final ack edge.
- **Zero-wait bus** (ack in the first `bus_req` cycle):
  - read or write: 1 stall cycle;
  - read+fetch miss: 2 stall cycles;
  - fetch hit: 0 stall cycles.
- **Result validity:** results are valid whenever `cpu_stall`=0 following the sampling edge, matching the one-cycle mic1 memory latency.
- **Bus rules:** `bus_addr`, `bus_we` and `bus_wdata` are stable while `bus_req`=1. `bus_req` is never high in IDLE.

## Configuration
- **`MIC1_FETCH_BUF_EN` defined:** fetch buffer present as described.
- **`MIC1_FETCH_BUF_EN` undefined:**
  - No buffer; every fetch takes FETCH and a bus transfer.
  - Write invalidation logic is removed.
  - Hit path is absent, so a fetch alone costs at least one stall cycle.

## Test plan
- **Read then write, ack after 0 wait cycles:** `cpu_read` with `cpu_addr`=0x10 and `bus_rdata`=0xDEADBEEF.
  - Required: `cpu_stall` high 1 cycle, then `cpu_rdata`=0xDEADBEEF.
  - Next, write 0x12345678 to 0x11: `bus_we`=1, `bus_addr`=0x11, `bus_wdata`=0x12345678 during `bus_req`.
- **Sequential fetch:** PC=0x100..0x103 over word 0xA1B2C3D4 (buffer enabled).
  - Required: one bus transfer, `cpu_ibyte` = A1, B2, C3, D4.
  - Stall only on the first fetch; PC=0x104 misses.
- **Write invalidates buffer:** `cpu_write` to word 0x40 while the buffer holds tag 0x40, with a fetch in the same cycle.
  - Required: DATA then FETCH, 2 stall cycles.
  - `cpu_ibyte` comes from the re-read word.
- **Timeout:** `TIMEOUT`=4, `bus_ack` held low on a read.
  - Required: `bus_req` high 4 cycles, `cpu_rdata`=0xFFFFFFFF, `err`=1 sticky, FSM returns to IDLE.
- **Illegal strobes and reset:** `cpu_read`+`cpu_write` both high, then `resetn` low during DATA.
  - Required: only a write occurs and `err`=1.
  - On reset: `bus_req` drops immediately, all outputs 0, next fetch misses.

Source files
------------

// File: rtl/mic1_mem_bridge.sv
// mic1_mem_bridge: serialises mic1 rd/wr/fetch strobes onto a single-port req/ack word bus.
// Define MIC1_FETCH_BUF_EN to add the one-word opcode fetch buffer.
module mic1_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_fetch,
  output logic [31:0] cpu_rdata,
  output logic [7:0]  cpu_ibyte,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        rd_q, wr_q, fe_q, rd_nxt, wr_nxt, fe_nxt;
  logic [31:0] addr_q, wdata_q, pc_q, addr_nxt, wdata_nxt, pc_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [31:0] rdata_nxt;
  logic [7:0]  ibyte_nxt;
  logic        err_nxt, done;
  logic        hit_new, hit_pend;
  logic [7:0]  hit_byte_new, hit_byte_pend;

  // Big-endian byte lane select within a word.
  function automatic logic [7:0] bsel(input logic [31:0] w, input logic [1:0] s);
    unique case (s)
      2'd0: return w[31:24];
      2'd1: return w[23:16];
      2'd2: return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign done      = bus_ack || (cnt == CNT_LAST);
  assign bus_req   = (state != IDLE);
  assign bus_we    = (state == DATA) && wr_q;
  assign bus_addr  = (state == FETCH) ? {2'b00, pc_q[31:2]} : addr_q;
  assign bus_wdata = wdata_q;

`ifdef MIC1_FETCH_BUF_EN
  logic        buf_vld;
  logic [29:0] buf_tag;
  logic [31:0] buf_word;
  logic        inval;

  // A pending fetch after a write to the buffered word must see the invalidation.
  assign inval         = wr_q && buf_vld && (addr_q == {2'b00, buf_tag});
  assign hit_new       = buf_vld && (cpu_pc[31:2] == buf_tag);
  assign hit_pend      = buf_vld && !inval && (pc_q[31:2] == buf_tag);
  assign hit_byte_new  = bsel(buf_word, cpu_pc[1:0]);
  assign hit_byte_pend = bsel(buf_word, pc_q[1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_word <= '0;
    end else if (state == FETCH && bus_ack) begin
      buf_vld  <= 1'b1;
      buf_tag  <= pc_q[31:2];
      buf_word <= bus_rdata;
    end else if (state == DATA && done && inval) begin
      buf_vld  <= 1'b0;
    end
  end
`else
  assign hit_new       = 1'b0;
  assign hit_pend      = 1'b0;
  assign hit_byte_new  = 8'h00;
  assign hit_byte_pend = 8'h00;
`endif

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    fe_nxt    = fe_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt + 16'd1;
    rdata_nxt = cpu_rdata;
    ibyte_nxt = cpu_ibyte;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!cpu_stall) begin
          rd_nxt    = cpu_read && !cpu_write;
          wr_nxt    = cpu_write;
          fe_nxt    = cpu_fetch;
          addr_nxt  = cpu_addr;
          wdata_nxt = cpu_wdata;
          pc_nxt    = cpu_pc;
          if (cpu_read && cpu_write) err_nxt = 1'b1;
          if (cpu_read || cpu_write) state_nxt = DATA;
          else if (cpu_fetch) begin
            if (hit_new) ibyte_nxt = hit_byte_new;
            else         state_nxt = FETCH;
          end
        end
      end
      DATA: begin
        if (done) begin
          cnt_nxt = '0;
          if (!bus_ack) begin
            err_nxt = 1'b1;
            if (rd_q) rdata_nxt = '1;
          end else if (rd_q) begin
            rdata_nxt = bus_rdata;
          end
          state_nxt = IDLE;
          if (fe_q) begin
            if (hit_pend) ibyte_nxt = hit_byte_pend;
            else          state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (done) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (bus_ack) ibyte_nxt = bsel(bus_rdata, pc_q[1:0]);
          else begin
            ibyte_nxt = 8'hFF;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      fe_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_ibyte <= '0;
      cpu_stall <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_q      <= rd_nxt;
      wr_q      <= wr_nxt;
      fe_q      <= fe_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      pc_q      <= pc_nxt;
      cnt       <= cnt_nxt;
      cpu_rdata <= rdata_nxt;
      cpu_ibyte <= ibyte_nxt;
      cpu_stall <= (state_nxt != IDLE);
      err       <= err_nxt;
    end
  end
endmodule
